ctrl_pipe_chain: RTL and testbench



---
 rtl/ctrl_pipe_chain.sv | 136 +++++++++++++
 tb/tb_ctrl_pipe_chain.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_chain.sv
// rtl/ctrl_pipe_chain.sv - ID/EX, EX/MEM, MEM/WB control-word pipeline with bubble insertion.
// Optional internal load-use detection when CTRL_PIPE_LOADUSE_EN is defined.
module ctrl_pipe_chain (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic       id_illegal,
    input  logic       id_reg_dst,
    input  logic       id_alu_src,
    input  logic       id_memto_reg,
    input  logic       id_reg_write,
    input  logic       id_mem_read,
    input  logic       id_mem_write,
    input  logic       id_branch,
    input  logic       id_jump,
    input  logic [1:0] id_alu_op,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       stall_in,
    input  logic       flush,
    output logic       stall_out,
    output logic       ex_valid,
    output logic       ex_reg_dst,
    output logic       ex_alu_src,
    output logic [1:0] ex_alu_op,
    output logic [4:0] ex_rt,
    output logic       mem_valid,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_branch,
    output logic       mem_jump,
    output logic       wb_valid,
    output logic       wb_reg_write,
    output logic       wb_memto_reg,
    output logic       illegal_seen
);

    // EX-stage bits that are not visible at EX but travel on to MEM/WB
    logic ex_memto_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump;
    logic mem_reg_write, mem_memto_reg;
    logic load_use;
    logic ex_load;

`ifdef CTRL_PIPE_LOADUSE_EN
    assign load_use = id_valid & ex_valid & ex_mem_read & (ex_rt != 5'd0) &
                      ((ex_rt == id_rs) | (ex_rt == id_rt));
`else
    logic unused_rs;
    assign unused_rs = ^id_rs;
    assign load_use  = 1'b0;
`endif

    assign stall_out = ~flush & (stall_in | load_use);
    assign ex_load   = ~flush & ~stall_out & id_valid & ~id_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_alu_op     <= 2'b00;
            ex_rt         <= 5'd0;
            ex_memto_reg  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_branch     <= 1'b0;
            ex_jump       <= 1'b0;
            mem_valid     <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_branch    <= 1'b0;
            mem_jump      <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_memto_reg <= 1'b0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_memto_reg  <= 1'b0;
            illegal_seen  <= 1'b0;
        end else begin
            // Bubbles load literal zeros so X control bits never reach a stage
            if (ex_load) begin
                ex_valid     <= 1'b1;
                ex_reg_dst   <= id_reg_dst;
                ex_alu_src   <= id_alu_src;
                ex_alu_op    <= id_alu_op;
                ex_rt        <= id_rt;
                ex_memto_reg <= id_memto_reg;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
                ex_mem_write <= id_mem_write;
                ex_branch    <= id_branch;
                ex_jump      <= id_jump;
            end else begin
                ex_valid     <= 1'b0;
                ex_reg_dst   <= 1'b0;
                ex_alu_src   <= 1'b0;
                ex_alu_op    <= 2'b00;
                ex_rt        <= 5'd0;
                ex_memto_reg <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_mem_write <= 1'b0;
                ex_branch    <= 1'b0;
                ex_jump      <= 1'b0;
            end

            if (flush) begin
                mem_valid     <= 1'b0;
                mem_read      <= 1'b0;
                mem_write     <= 1'b0;
                mem_branch    <= 1'b0;
                mem_jump      <= 1'b0;
                mem_reg_write <= 1'b0;
                mem_memto_reg <= 1'b0;
            end else begin
                mem_valid     <= ex_valid;
                mem_read      <= ex_mem_read;
                mem_write     <= ex_mem_write;
                mem_branch    <= ex_branch;
                mem_jump      <= ex_jump;
                mem_reg_write <= ex_reg_write;
                mem_memto_reg <= ex_memto_reg;
            end

            // The resolving branch in MEM retires even when it flushes younger stages
            wb_valid     <= mem_valid;
            wb_reg_write <= mem_reg_write;
            wb_memto_reg <= mem_memto_reg;

            if (id_valid & id_illegal & ~flush)
                illegal_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb/tb_ctrl_pipe_chain.sv - directed self-checking bench for ctrl_pipe_chain.
module tb_ctrl_pipe_chain;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_illegal;
    logic       id_reg_dst, id_alu_src, id_memto_reg, id_reg_write;
    logic       id_mem_read, id_mem_write, id_branch, id_jump;
    logic [1:0] id_alu_op;
    logic [4:0] id_rs, id_rt;
    logic       stall_in, flush;
    logic       stall_out;
    logic       ex_valid, ex_reg_dst, ex_alu_src;
    logic [1:0] ex_alu_op;
    logic [4:0] ex_rt;
    logic       mem_valid, mem_read, mem_write, mem_branch, mem_jump;
    logic       wb_valid, wb_reg_write, wb_memto_reg;
    logic       illegal_seen;

    int pass_count = 0;
    int total = 0;

    ctrl_pipe_chain dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_illegal(id_illegal),
        .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src),
        .id_memto_reg(id_memto_reg), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_jump(id_jump),
        .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt),
        .stall_in(stall_in), .flush(flush), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
        .ex_alu_op(ex_alu_op), .ex_rt(ex_rt),
        .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
        .mem_branch(mem_branch), .mem_jump(mem_jump),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_memto_reg(wb_memto_reg),
        .illegal_seen(illegal_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) pass_count++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_illegal = 0;
        id_reg_dst = 0; id_alu_src = 0; id_memto_reg = 0; id_reg_write = 0;
        id_mem_read = 0; id_mem_write = 0; id_branch = 0; id_jump = 0;
        id_alu_op = 2'b00; id_rs = 0; id_rt = 0;
    endtask

    task automatic rfmt(input logic [4:0] rs, input logic [4:0] rt);
        idle();
        id_valid = 1; id_reg_dst = 1; id_reg_write = 1; id_alu_op = 2'b10;
        id_rs = rs; id_rt = rt;
    endtask

    task automatic lw(input logic [4:0] rs, input logic [4:0] rt);
        idle();
        id_valid = 1; id_alu_src = 1; id_memto_reg = 1; id_reg_write = 1; id_mem_read = 1;
        id_rs = rs; id_rt = rt;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_valids"}, {5'd0, ex_valid, mem_valid, wb_valid}, 8'd0);
        chk({tag, "_ex"}, {ex_reg_dst, ex_alu_src, ex_alu_op, 4'd0}, 8'd0);
        chk({tag, "_ex_rt"}, {3'd0, ex_rt}, 8'd0);
        chk({tag, "_mem"}, {4'd0, mem_read, mem_write, mem_branch, mem_jump}, 8'd0);
        chk({tag, "_wb"}, {6'd0, wb_reg_write, wb_memto_reg}, 8'd0);
    endtask

    initial begin
        rst = 1; stall_in = 0; flush = 0;
        idle();
        #1;
        all_zero("reset");
        chk("reset_illegal", {7'd0, illegal_seen}, 8'd0);
        chk("reset_stall", {7'd0, stall_out}, 8'd0);
        step(); step();
        rst = 0;

        // R-format: EX at n+1, MEM n+2, WB n+3
        rfmt(5'd1, 5'd3);
        step();
        idle();
        chk("r_ex_valid", {7'd0, ex_valid}, 8'd1);
        chk("r_ex_alu_op", {6'd0, ex_alu_op}, 8'd2);
        chk("r_ex_reg_dst", {7'd0, ex_reg_dst}, 8'd1);
        chk("r_ex_rt", {3'd0, ex_rt}, 8'd3);
        step();
        chk("r_mem", {3'd0, mem_valid, mem_read, mem_write, mem_branch, mem_jump}, 8'h10);
        chk("r_ex_drained", {7'd0, ex_valid}, 8'd0);
        step();
        chk("r_wb", {5'd0, wb_valid, wb_reg_write, wb_memto_reg}, 8'd6);
        step(); step();

        // Load-use: LW rt=5 followed by ADDIU rs=5
        lw(5'd1, 5'd5);
        #1;
        chk("lu_no_stall_first", {7'd0, stall_out}, 8'd0);
        step();
        idle();
        id_valid = 1; id_alu_src = 1; id_reg_write = 1; id_rs = 5'd5; id_rt = 5'd6;
        #1;
`ifdef CTRL_PIPE_LOADUSE_EN
        chk("lu_stall", {7'd0, stall_out}, 8'd1);
        step();
        chk("lu_bubble", {7'd0, ex_valid}, 8'd0);
        chk("lu_lw_in_mem", {6'd0, mem_valid, mem_read}, 8'd3);
        chk("lu_stall_released", {7'd0, stall_out}, 8'd0);
        step();
        idle();
        chk("lu_addiu_ex", {2'd0, ex_valid, ex_rt}, 8'h26);
`else
        chk("lu_nostall", {7'd0, stall_out}, 8'd0);
        step();
        idle();
        chk("lu_addiu_ex", {2'd0, ex_valid, ex_rt}, 8'h26);
        chk("lu_lw_in_mem", {6'd0, mem_valid, mem_read}, 8'd3);
`endif
        step(); step(); step();

        // Flush: BEQ in MEM, LW in EX, SW in ID
        idle();
        id_valid = 1; id_branch = 1; id_alu_op = 2'b01; id_rs = 5'd1; id_rt = 5'd2;
        step();
        lw(5'd8, 5'd7);
        step();
        idle();
        id_valid = 1; id_alu_src = 1; id_mem_write = 1; id_rs = 5'd9; id_rt = 5'd7;
        flush = 1;
        #1;
        chk("fl_pre_mem_branch", {6'd0, mem_valid, mem_branch}, 8'd3);
        chk("fl_pre_ex_lw", {2'd0, ex_valid, ex_rt}, 8'h27);
        chk("fl_stall_forced0", {7'd0, stall_out}, 8'd0);
        step();
        flush = 0;
        idle();
        chk("fl_ex_mem", {4'd0, ex_valid, mem_valid, mem_read, mem_write}, 8'd0);
        chk("fl_wb_beq", {6'd0, wb_valid, wb_reg_write}, 8'd2);
        chk("fl_no_illegal", {7'd0, illegal_seen}, 8'd0);
        step(); step();

        // Illegal opcode alongside flush must not set the flag
        id_valid = 1; id_illegal = 1; flush = 1;
        step();
        flush = 0;
        chk("ill_flush_noset", {7'd0, illegal_seen}, 8'd0);
        id_reg_dst = 'x; id_alu_src = 'x; id_memto_reg = 'x; id_reg_write = 'x;
        id_mem_read = 'x; id_mem_write = 'x; id_branch = 'x; id_jump = 'x;
        id_alu_op = 'x; id_rs = 'x; id_rt = 'x;
        step();
        chk("ill_ex", {3'd0, ex_valid, ex_reg_dst, ex_alu_src, ex_alu_op}, 8'd0);
        chk("ill_ex_rt", {3'd0, ex_rt}, 8'd0);
        chk("ill_seen", {7'd0, illegal_seen}, 8'd1);
        idle();
        step(); step(); step();
        chk("ill_held", {7'd0, illegal_seen}, 8'd1);
        all_zero("ill_drain");

        // stall_in alone: bubble into EX while the older instruction drains
        rfmt(5'd2, 5'd4);
        step();
        stall_in = 1;
        #1;
        chk("st_stall_out", {7'd0, stall_out}, 8'd1);
        step();
        chk("st_drain", {6'd0, ex_valid, mem_valid}, 8'd1);

        // stall_in and flush together: flush wins
        flush = 1;
        #1;
        chk("sf_stall_out", {7'd0, stall_out}, 8'd0);
        step();
        stall_in = 0; flush = 0;
        chk("sf_bubbles", {6'd0, ex_valid, mem_valid}, 8'd0);
        chk("sf_wb_old", {6'd0, wb_valid, wb_reg_write}, 8'd3);
        idle();
        step(); step();

        // Asynchronous reset with three instructions in flight
        rfmt(5'd1, 5'd10); step();
        lw(5'd2, 5'd11);   step();
        rfmt(5'd3, 5'd12); step();
        idle();
        chk("rs_inflight", {5'd0, ex_valid, mem_valid, wb_valid}, 8'd7);
        #2;
        rst = 1;
        #1;
        all_zero("async_rst");
        chk("async_rst_illegal", {7'd0, illegal_seen}, 8'd0);
        step();
        rst = 0;

        $display("%0d/%0d checks passed", pass_count, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
